// File: rtl/register_file_pkg.sv
// Shared widths and types for the architectural register file and its read ports.
package register_file_pkg;

  localparam int ROB_WIDTH_BIT = 4;
  localparam int REG_ID_BIT    = 5;
  localparam int REG_COUNT     = 32;
  localparam int DATA_W        = 32;

  typedef logic [REG_ID_BIT-1:0] reg_id_t;
  typedef logic [DATA_W-1:0]     data_t;

endpackage

// File: rtl/register_file_read_port.sv
// One decoder source port: selects value/busy/tag by id, forces x0 and applies the commit bypass.
module register_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = register_file_pkg::ROB_WIDTH_BIT
) (
  input  logic [REG_ID_BIT-1:0]                    rd_id_i,
  input  logic [REG_COUNT-1:0][DATA_W-1:0]         vals_i,
  input  logic [REG_COUNT-1:0]                     busy_i,
  input  logic [REG_COUNT-1:0][ROB_WIDTH_BIT-1:0]  tags_i,
  input  logic                                     byp_en_i,
  input  logic [REG_ID_BIT-1:0]                    commit_id_i,
  input  logic [DATA_W-1:0]                        commit_val_i,
  input  logic [ROB_WIDTH_BIT-1:0]                 commit_rob_i,
  output logic [DATA_W-1:0]                        rd_val_o,
  output logic                                     rd_busy_o,
  output logic [ROB_WIDTH_BIT-1:0]                 rd_rob_o
);

  always_comb begin
    rd_val_o  = '0;
    rd_busy_o = 1'b0;
    rd_rob_o  = '0;
    if (rd_id_i != '0) begin
      // The producer we would wait on is committing right now: hand over its value.
      if (byp_en_i && (commit_id_i == rd_id_i) && busy_i[rd_id_i] &&
          (tags_i[rd_id_i] == commit_rob_i)) begin
        rd_val_o = commit_val_i;
      end else begin
        rd_val_o  = vals_i[rd_id_i];
        rd_busy_o = busy_i[rd_id_i];
        rd_rob_o  = busy_i[rd_id_i] ? tags_i[rd_id_i] : '0;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and youngest-producer RoB tag.
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = register_file_pkg::ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [REG_ID_BIT-1:0]    set_reg_id,
  input  logic [DATA_W-1:0]        set_val,
  input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  input  logic [REG_ID_BIT-1:0]    set_dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic [REG_ID_BIT-1:0]    rs1_id,
  input  logic [REG_ID_BIT-1:0]    rs2_id,
  output logic [DATA_W-1:0]        rs1_val,
  output logic [DATA_W-1:0]        rs2_val,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs1_rob,
  output logic [ROB_WIDTH_BIT-1:0] rs2_rob
);

  logic [REG_COUNT-1:0][DATA_W-1:0]        val_q,  val_d;
  logic [REG_COUNT-1:0]                    busy_q, busy_d;
  logic [REG_COUNT-1:0][ROB_WIDTH_BIT-1:0] tag_q,  tag_d;
  logic                                    byp_en;

  // rdy_in is a global enable: when low, nothing moves and commit bypass is off.
  assign byp_en = rdy_in && !clear;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (clear) begin
        busy_d = '0;
        tag_d  = '0;
      end else begin
        if (set_reg_id != '0) begin
          val_d[set_reg_id] = set_val;
          if (busy_q[set_reg_id] && (tag_q[set_reg_id] == set_reg_on_rob_id)) begin
            busy_d[set_reg_id] = 1'b0;
          end
        end
        // Dep is applied after commit so a same-register issue keeps the new producer.
        if (set_dep_reg_id != '0) begin
          busy_d[set_dep_reg_id] = 1'b1;
          tag_d[set_dep_reg_id]  = set_dep_rob_id;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  register_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs1 (
    .rd_id_i      (rs1_id),
    .vals_i       (val_q),
    .busy_i       (busy_q),
    .tags_i       (tag_q),
    .byp_en_i     (byp_en),
    .commit_id_i  (set_reg_id),
    .commit_val_i (set_val),
    .commit_rob_i (set_reg_on_rob_id),
    .rd_val_o     (rs1_val),
    .rd_busy_o    (rs1_busy),
    .rd_rob_o     (rs1_rob)
  );

  register_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs2 (
    .rd_id_i      (rs2_id),
    .vals_i       (val_q),
    .busy_i       (busy_q),
    .tags_i       (tag_q),
    .byp_en_i     (byp_en),
    .commit_id_i  (set_reg_id),
    .commit_val_i (set_val),
    .commit_rob_i (set_reg_on_rob_id),
    .rd_val_o     (rs2_val),
    .rd_busy_o    (rs2_busy),
    .rd_rob_o     (rs2_rob)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus a randomized run against a behavioural model.
module tb_register_file;
  import register_file_pkg::*;

  localparam int RW    = ROB_WIDTH_BIT;
  localparam int OBS_W = DATA_W + 1 + RW;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, clear;
  logic [4:0]        set_reg_id, set_dep_reg_id, rs1_id, rs2_id;
  logic [31:0]       set_val, rs1_val, rs2_val;
  logic [RW-1:0]     set_reg_on_rob_id, set_dep_rob_id, rs1_rob, rs2_rob;
  logic              rs1_busy, rs2_busy;

  logic [OBS_W-1:0]  exp_q[$];
  logic [OBS_W-1:0]  obs1, obs2, got, exp_v;
  int                total = 0;
  int                bad   = 0;

  logic [31:0]       m_val  [REG_COUNT];
  logic              m_busy [REG_COUNT];
  logic [RW-1:0]     m_tag  [REG_COUNT];

  register_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob(rs1_rob), .rs2_rob(rs2_rob)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  assign obs1 = {rs1_val, rs1_busy, rs1_rob};
  assign obs2 = {rs2_val, rs2_busy, rs2_rob};

  function automatic logic [OBS_W-1:0] pk(input logic [31:0] v, input logic b, input logic [RW-1:0] r);
    return {v, b, r};
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0;
    set_reg_id = '0; set_val = '0; set_reg_on_rob_id = '0;
    set_dep_reg_id = '0; set_dep_rob_id = '0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RW-1:0] t);
    set_reg_id = r; set_val = v; set_reg_on_rob_id = t;
  endtask

  task automatic dep(input logic [4:0] r, input logic [RW-1:0] t);
    set_dep_reg_id = r; set_dep_rob_id = t;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1; rs1_id = '0; rs2_id = '0;
    cyc(); cyc();
    rst_in = 1'b0;
    rs1_id = 5'd5; rs2_id = 5'd0;
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    #2;
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL reset_rs%0d: got %h want %h", p + 1, got, exp_v); end
    end
  endtask

  task automatic test_dep_commit_bypass();
    idle(); dep(5'd3, 4'd2); cyc();
    idle(); rs1_id = 5'd3; rs2_id = 5'd0;
    exp_q.push_back(pk(32'h0, 1'b1, 4'd2));
    commit(5'd3, 32'hDEAD, 4'd2);
    exp_q.push_back(pk(32'hDEAD, 1'b0, '0));
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin set_reg_id = '0; #2; end else #2;
      if (k == 0) commit(5'd3, 32'hDEAD, 4'd2);
      got = obs1; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL dep_commit_step%0d: got %h want %h", k, got, exp_v); end
    end
    cyc(); idle();
    exp_q.push_back(pk(32'hDEAD, 1'b0, '0));
    #2;
    got = obs1; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL dep_commit_registered: got %h want %h", got, exp_v); end
  endtask

  task automatic test_tag_mismatch();
    idle(); dep(5'd4, 4'd1); cyc();
    idle(); dep(5'd4, 4'd5); cyc();
    idle(); commit(5'd4, 32'h11, 4'd1); rs1_id = 5'd4;
    exp_q.push_back(pk(32'h0, 1'b1, 4'd5));
    #2;
    got = obs1; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL mismatch_same_cycle: got %h want %h", got, exp_v); end
    cyc(); idle();
    exp_q.push_back(pk(32'h11, 1'b1, 4'd5));
    #2;
    got = obs1; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL mismatch_after: got %h want %h", got, exp_v); end
  endtask

  task automatic test_commit_dep_same_reg();
    idle(); dep(5'd6, 4'd3); cyc();
    idle(); commit(5'd6, 32'h22, 4'd3); dep(5'd6, 4'd7); rs1_id = 5'd6;
    exp_q.push_back(pk(32'h22, 1'b0, '0));
    #2;
    got = obs1; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL samereg_bypass: got %h want %h", got, exp_v); end
    cyc(); idle();
    exp_q.push_back(pk(32'h22, 1'b1, 4'd7));
    #2;
    got = obs1; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL samereg_after: got %h want %h", got, exp_v); end
  endtask

  task automatic test_clear();
    idle(); dep(5'd1, 4'd1); cyc();
    idle(); dep(5'd2, 4'd2); cyc();
    idle(); clear = 1'b1; commit(5'd1, 32'h99, 4'd1); rs1_id = 5'd1; rs2_id = 5'd2;
    exp_q.push_back(pk(32'h0, 1'b1, 4'd1));
    exp_q.push_back(pk(32'h0, 1'b1, 4'd2));
    #2;
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL clear_during_rs%0d: got %h want %h", p + 1, got, exp_v); end
    end
    cyc(); idle();
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    #2;
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL clear_after_rs%0d: got %h want %h", p + 1, got, exp_v); end
    end
  endtask

  task automatic test_rdy_and_x0();
    // busy x8 first so a frozen commit would otherwise be bypassed
    idle(); dep(5'd8, 4'd0); cyc();
    idle(); rdy_in = 1'b0; commit(5'd8, 32'h5, 4'd0); dep(5'd9, 4'd4);
    rs1_id = 5'd8; rs2_id = 5'd9;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pk(32'h0, 1'b1, 4'd0));
      exp_q.push_back(pk(32'h0, 1'b0, '0));
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL rdy_low_k%0d_rs%0d: got %h want %h", k, p + 1, got, exp_v); end
      end
      cyc();
    end
    idle(); commit(5'd0, 32'h7, 4'd0); dep(5'd0, 4'd1); rs1_id = 5'd0; rs2_id = 5'd0;
    cyc(); idle();
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    exp_q.push_back(pk(32'h0, 1'b0, '0));
    #2;
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL x0_rs%0d: got %h want %h", p + 1, got, exp_v); end
    end
  endtask

  function automatic logic [OBS_W-1:0] model_read(input logic [4:0] id);
    if (id == 5'd0) return pk(32'h0, 1'b0, '0);
    if (rdy_in && !clear && set_reg_id == id && m_busy[id] && m_tag[id] == set_reg_on_rob_id)
      return pk(set_val, 1'b0, '0);
    return pk(m_val[id], m_busy[id], m_busy[id] ? m_tag[id] : '0);
  endfunction

  task automatic test_random();
    logic [4:0] r;
    idle(); rst_in = 1'b1; cyc(); rst_in = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
    for (int n = 0; n < 300; n++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 15) == 0);
      r = 5'($urandom_range(0, 31));
      set_reg_id = ($urandom_range(0, 3) == 0) ? 5'd0 : r;
      set_val = $urandom;
      set_reg_on_rob_id = (m_busy[r] && $urandom_range(0, 2) != 0) ? m_tag[r] : RW'($urandom_range(0, 15));
      set_dep_reg_id = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      set_dep_rob_id = RW'($urandom_range(0, 15));
      rs1_id = ($urandom_range(0, 1) == 0) ? r : 5'($urandom_range(0, 31));
      rs2_id = 5'($urandom_range(0, 31));
      exp_q.push_back(model_read(rs1_id));
      exp_q.push_back(model_read(rs2_id));
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? obs1 : obs2; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL random_n%0d_rs%0d: got %h want %h", n, p + 1, got, exp_v); end
      end
      if (rdy_in) begin
        if (clear) begin
          for (int i = 0; i < REG_COUNT; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
        end else begin
          if (set_reg_id != 0) begin
            m_val[set_reg_id] = set_val;
            if (m_busy[set_reg_id] && m_tag[set_reg_id] == set_reg_on_rob_id) m_busy[set_reg_id] = 1'b0;
          end
          if (set_dep_reg_id != 0) begin
            m_busy[set_dep_reg_id] = 1'b1;
            m_tag[set_dep_reg_id]  = set_dep_rob_id;
          end
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    rst_in = 1'b1; idle(); rs1_id = '0; rs2_id = '0;
    test_reset();
    test_dep_commit_bypass();
    test_tag_mismatch();
    test_commit_dep_same_reg();
    test_clear();
    test_rdy_and_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
